// File: rtl/c1_mem_responder_if.sv
// C1/A1/D1 bus shared by a CPU (master) and the memory responder (slave).
// Each agent drives C1/D1 through its own value/enable pair; the resolved lines float when neither drives.
interface c1_mem_responder_if;
  logic [14:0] A1;
  logic [2:0]  C1;
  logic [15:0] D1;
  logic        busy;

  logic [2:0]  cpu_c1;
  logic        cpu_c1_oe;
  logic [15:0] cpu_d1;
  logic        cpu_d1_oe;

  logic [2:0]  rsp_c1;
  logic        rsp_c1_oe;
  logic [15:0] rsp_d1;
  logic        rsp_d1_oe;

  assign C1 = rsp_c1_oe ? rsp_c1 : (cpu_c1_oe ? cpu_c1 : 'z);
  assign D1 = rsp_d1_oe ? rsp_d1 : (cpu_d1_oe ? cpu_d1 : 'z);

  modport master (
    output A1, cpu_c1, cpu_c1_oe, cpu_d1, cpu_d1_oe,
    input  C1, D1, busy
  );

  modport slave (
    input  A1, C1, D1,
    output rsp_c1, rsp_c1_oe, rsp_d1, rsp_d1_oe, busy
  );
endinterface

// File: rtl/c1_mem_responder.sv
// Bus-1 memory responder: decodes a two-tick CPU command, holds C1_NOP for RESP_DELAY
// cycles, then answers with C1_RESPONSE (and read data) from a byte-addressed store.
module c1_mem_responder #(
  parameter int unsigned MEM_SIZE   = 524288,
  parameter int unsigned RESP_DELAY = 4,
  parameter int unsigned LINE_SIZE  = 16
) (
  input  logic clk,
  input  logic reset,
  c1_mem_responder_if.slave bus
);
  localparam int unsigned AW    = $clog2(MEM_SIZE);
  localparam int unsigned OFF_W = $clog2(LINE_SIZE);
  localparam int unsigned TS_W  = AW - OFF_W;
  localparam int unsigned CNT_W = $clog2(RESP_DELAY + 1);
  localparam logic [2:0]  C1_RESPONSE = 3'd7;

  typedef enum logic [2:0] {
    C1_NOP             = 3'd0,
    C1_READ8           = 3'd1,
    C1_READ16          = 3'd2,
    C1_READ32          = 3'd3,
    C1_INVALIDATE_LINE = 3'd4,
    C1_WRITE8          = 3'd5,
    C1_WRITE16         = 3'd6,
    C1_WRITE32         = 3'd7
  } cmd_t;

  typedef enum logic [2:0] {S_IDLE, S_ADDR2, S_WAIT, S_RESP1, S_RESP2} state_t;

  state_t            r_state, w_next;
  cmd_t              r_cmd;
  logic [TS_W-1:0]   r_ts;
  logic [OFF_W-1:0]  r_off;
  logic [15:0]       r_dlo, r_dhi;
  logic [31:0]       r_rdata;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_commit;
  logic [AW-1:0]     w_addr  [4];
  logic [7:0]        w_rbyte [4];
  logic [31:0]       w_wdata;
  logic [2:0]        w_nwrite;

  // Bytes are stored XORed with their low address byte, so zero-initialised storage
  // reads back as byte[a] = a[7:0].
  logic [7:0] r_mem [MEM_SIZE];

  assign w_commit = (r_state == S_WAIT) && (r_cnt == '0);
  assign w_wdata  = {r_dhi, r_dlo};

  always_comb begin
    w_nwrite = 3'd0;
    case (r_cmd)
      C1_WRITE8:  w_nwrite = 3'd1;
      C1_WRITE16: w_nwrite = 3'd2;
      C1_WRITE32: w_nwrite = 3'd4;
      default:    w_nwrite = 3'd0;
    endcase
    for (int unsigned i = 0; i < 4; i++) begin
      w_addr[i]  = {r_ts, r_off + OFF_W'(i)};
      w_rbyte[i] = r_mem[w_addr[i]] ^ w_addr[i][7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_ADDR2)
        r_cnt <= CNT_W'(RESP_DELAY - 1);
      else if (r_state == S_WAIT && r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.C1 != '0) w_next = S_ADDR2;
      S_ADDR2: w_next = S_WAIT;
      S_WAIT:  if (r_cnt == '0) w_next = S_RESP1;
      S_RESP1: w_next = (r_cmd == C1_READ32) ? S_RESP2 : S_IDLE;
      S_RESP2: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd   <= C1_NOP;
      r_ts    <= '0;
      r_off   <= '0;
      r_dlo   <= '0;
      r_dhi   <= '0;
      r_rdata <= '0;
    end else begin
      if (r_state == S_IDLE && w_next == S_ADDR2) begin
        r_cmd <= cmd_t'(bus.C1);
        r_ts  <= bus.A1[TS_W-1:0];
        r_dlo <= bus.D1;
      end
      if (r_state == S_ADDR2) begin
        r_off <= bus.A1[OFF_W-1:0];
        r_dhi <= bus.D1;
      end
      if (w_commit)
        r_rdata <= {w_rbyte[3], w_rbyte[2], w_rbyte[1], w_rbyte[0]};
    end
  end

  // Writes land on the edge entering RESP1; an earlier reset leaves the store untouched.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int unsigned i = 0; i < 4; i++)
        if (3'(i) < w_nwrite)
          r_mem[w_addr[i]] <= w_wdata[8*i +: 8] ^ w_addr[i][7:0];
    end
  end

  always_comb begin
    bus.rsp_c1    = C1_NOP;
    bus.rsp_c1_oe = 1'b0;
    bus.rsp_d1    = '0;
    bus.rsp_d1_oe = 1'b0;
    bus.busy      = (r_state != S_IDLE);
    case (r_state)
      S_WAIT: bus.rsp_c1_oe = 1'b1;
      S_RESP1: begin
        bus.rsp_c1    = C1_RESPONSE;
        bus.rsp_c1_oe = 1'b1;
        case (r_cmd)
          C1_READ8: begin
            bus.rsp_d1    = {8'h00, r_rdata[7:0]};
            bus.rsp_d1_oe = 1'b1;
          end
          C1_READ16, C1_READ32: begin
            bus.rsp_d1    = r_rdata[15:0];
            bus.rsp_d1_oe = 1'b1;
          end
          default: bus.rsp_d1_oe = 1'b0;
        endcase
      end
      S_RESP2: begin
        bus.rsp_c1    = C1_RESPONSE;
        bus.rsp_c1_oe = 1'b1;
        bus.rsp_d1    = r_rdata[31:16];
        bus.rsp_d1_oe = 1'b1;
      end
      default: bus.rsp_c1_oe = 1'b0;
    endcase
  end
endmodule
